// File: rtl/fa_pkg.sv
// Shared definitions for the accelerator's execution units: op codes, datapath
// widths and the max-pool engine's state encoding.
package fa_pkg;

   localparam logic [2:0] OP_IDLE         = 3'd0;
   localparam logic [2:0] OP_CONV1X1      = 3'd1;
   localparam logic [2:0] OP_CONV3X3      = 3'd2;
   localparam logic [2:0] OP_CONV_MIX     = 3'd3;
   localparam logic [2:0] OP_MAXPOOL3X3   = 3'd4;
   localparam logic [2:0] OP_AVEPOOL13X13 = 3'd5;

   localparam int FA_DATA_W = 16;
   localparam int FA_N_PAR  = 16;
   localparam int MP_KERNEL = 9;

   typedef enum logic [1:0] {
      MP_IDLE  = 2'd0,
      MP_READ  = 2'd1,
      MP_WRITE = 2'd2,
      MP_DONE  = 2'd3
   } mp_state_t;

endpackage

// File: rtl/max_reduce.sv
// Signed running-max accumulator: clear to most-negative, load first tap,
// then keep the larger of accumulator and incoming word.
module max_reduce #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] acc
);

   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= MOST_NEG;
      end else if (clear) begin
         acc <= MOST_NEG;
      end else if (load) begin
         acc <= din;
      end else if (en && ($signed(din) > $signed(acc))) begin
         acc <= din;
      end
   end

endmodule

// File: rtl/maxpool_engine.sv
// 3x3 max-pooling unit: pops 9-word windows from the data FIFO and pushes one
// signed maximum per window; pulses maxpool_valid after each group of LANES.
module maxpool_engine
   import fa_pkg::*;
#(
   parameter int DATA_W = FA_DATA_W,
   parameter int LANES  = FA_N_PAR,
   parameter int KERNEL = MP_KERNEL
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              maxpool_ready,
   output logic              maxpool_valid,
   input  logic [DATA_W-1:0] data_fifo_dout,
   input  logic              data_fifo_empty,
   output logic              data_fifo_rd_en,
   output logic [DATA_W-1:0] out_fifo_din,
   output logic              out_fifo_wr_en,
   input  logic              out_fifo_full,
   output logic              busy
);

   localparam int ISS_W  = $clog2(KERNEL + 1);
   localparam int TAP_W  = $clog2(KERNEL + 1);
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

   mp_state_t          state;
   mp_state_t          state_nxt;
   logic [ISS_W-1:0]   issued;
   logic [TAP_W-1:0]   tap_cnt;
   logic [LANE_W-1:0]  lane_cnt;
   logic               rd_pending;
   logic               win_start;
   logic               last_tap;
   logic [DATA_W-1:0]  max_acc;

   always_comb begin
      state_nxt       = state;
      win_start       = 1'b0;
      data_fifo_rd_en = 1'b0;
      out_fifo_wr_en  = 1'b0;
      out_fifo_din    = '0;
      maxpool_valid   = 1'b0;
      busy            = (state != MP_IDLE);
      last_tap        = rd_pending && (tap_cnt == TAP_W'(KERNEL - 1));
      case (state)
         MP_IDLE: begin
            if (maxpool_ready) begin
               state_nxt = MP_READ;
               win_start = 1'b1;
            end
         end
         MP_READ: begin
            // Gating on the live empty flag keeps back-to-back pops safe.
            data_fifo_rd_en = !data_fifo_empty && (issued < ISS_W'(KERNEL));
            if (last_tap) begin
               state_nxt = MP_WRITE;
            end
         end
         MP_WRITE: begin
            out_fifo_din = max_acc;
            if (!out_fifo_full) begin
               out_fifo_wr_en = 1'b1;
               if (lane_cnt == LANE_W'(LANES - 1)) begin
                  state_nxt = MP_DONE;
               end else begin
                  state_nxt = MP_READ;
                  win_start = 1'b1;
               end
            end
         end
         MP_DONE: begin
            maxpool_valid = 1'b1;
            if (maxpool_ready) begin
               state_nxt = MP_READ;
               win_start = 1'b1;
            end else begin
               state_nxt = MP_IDLE;
            end
         end
         default: state_nxt = MP_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= MP_IDLE;
         issued     <= '0;
         tap_cnt    <= '0;
         lane_cnt   <= '0;
         rd_pending <= 1'b0;
      end else begin
         state      <= state_nxt;
         rd_pending <= data_fifo_rd_en;
         if (win_start) begin
            issued  <= '0;
            tap_cnt <= '0;
         end else begin
            if (data_fifo_rd_en) issued  <= issued + 1'b1;
            if (rd_pending)      tap_cnt <= tap_cnt + 1'b1;
         end
         if (state == MP_DONE || state == MP_IDLE) begin
            lane_cnt <= '0;
         end else if (out_fifo_wr_en) begin
            lane_cnt <= lane_cnt + 1'b1;
         end
      end
   end

   // Tap 0 loads straight in so the clear value never takes part in a compare.
   max_reduce #(.W(DATA_W)) u_max_reduce (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (win_start),
      .load  (rd_pending && (tap_cnt == '0)),
      .en    (rd_pending),
      .din   (data_fifo_dout),
      .acc   (max_acc)
   );

endmodule

// File: tb/tb_maxpool_engine.sv
// Directed bench for maxpool_engine with FIFO models on both sides and a
// scoreboard of hand-computed window maxima.
module tb_maxpool_engine;

   logic        clk;
   logic        rst_n;
   logic        maxpool_ready;
   logic        maxpool_valid;
   logic [15:0] data_fifo_dout;
   logic        data_fifo_empty;
   logic        data_fifo_rd_en;
   logic [15:0] out_fifo_din;
   logic        out_fifo_wr_en;
   logic        out_fifo_full;
   logic        busy;

   maxpool_engine dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .maxpool_ready   (maxpool_ready),
      .maxpool_valid   (maxpool_valid),
      .data_fifo_dout  (data_fifo_dout),
      .data_fifo_empty (data_fifo_empty),
      .data_fifo_rd_en (data_fifo_rd_en),
      .out_fifo_din    (out_fifo_din),
      .out_fifo_wr_en  (out_fifo_wr_en),
      .out_fifo_full   (out_fifo_full),
      .busy            (busy)
   );

   // clock / cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard state
   logic [15:0] fifo_q[$];
   logic [15:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int pop_cnt, wr_cnt, valid_cnt, grp_wr, valid_cyc, t_start;
   logic pop_req = 1'b0;
   logic [15:0] sgn_w0 [9];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // data FIFO model: standard read, data appears the cycle after rd_en
   always @(posedge clk) begin
      if (pop_req && fifo_q.size() > 0) begin
         data_fifo_dout  <= fifo_q.pop_front();
         data_fifo_empty <= (fifo_q.size() == 0);
      end
   end

   // monitor, sampled on the falling edge
   always @(negedge clk) begin
      pop_req = data_fifo_rd_en;
      if (data_fifo_rd_en) begin
         check("rd_while_empty", 32'(data_fifo_empty), 32'd0);
         pop_cnt++;
      end
      if (out_fifo_wr_en) begin
         check("wr_while_full", 32'(out_fifo_full), 32'd0);
         check("pops_at_write", 32'(pop_cnt), 32'(9 * (wr_cnt + 1)));
         if (exp_q.size() > 0) check("out_din", 32'(out_fifo_din), 32'(exp_q.pop_front()));
         else                  check("out_unexpected", 32'(exp_q.size()), 32'd1);
         wr_cnt++;
         grp_wr++;
      end
      if (maxpool_valid) begin
         check("writes_per_group", 32'(grp_wr), 32'd16);
         grp_wr = 0;
         valid_cnt++;
         valid_cyc = cyc;
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [15:0] w);
      fifo_q.push_back(w);
      data_fifo_empty = 1'b0;
   endtask

   task automatic clr_counts();
      pop_cnt = 0; wr_cnt = 0; valid_cnt = 0; grp_wr = 0;
   endtask

   task automatic start_group(input bit keep);
      maxpool_ready = 1'b1;
      for (int i = 0; i < 10 && !busy; i++) tick();
      check("start_busy", 32'(busy), 32'd1);
      t_start = cyc;
      if (!keep) maxpool_ready = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget && busy; i++) tick();
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic end_checks(input string tag, input int wr, input int vl, input int pops);
      check({tag, "_writes"}, 32'(wr_cnt), 32'(wr));
      check({tag, "_valids"}, 32'(valid_cnt), 32'(vl));
      check({tag, "_pops"}, 32'(pop_cnt), 32'(pops));
      check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_outs_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_valid"}, 32'(maxpool_valid), 32'd0);
      check({tag, "_rd_en"}, 32'(data_fifo_rd_en), 32'd0);
      check({tag, "_wr_en"}, 32'(out_fifo_wr_en), 32'd0);
      check({tag, "_din"}, 32'(out_fifo_din), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] first_exp;
      int v;
      rst_n = 1'b0; maxpool_ready = 1'b0; out_fifo_full = 1'b0;
      data_fifo_empty = 1'b1; data_fifo_dout = 16'h0;
      clr_counts();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outs_zero("reset");
      tick();
      rst_n = 1'b1;
      tick();

      // basic group: window k = k*10+0..8
      clr_counts();
      for (int k = 0; k < 16; k++) begin
         for (int t = 0; t < 9; t++) push_word(16'(k * 10 + t));
         exp_q.push_back(16'(k * 10 + 8));
      end
      start_group(1'b0);
      wait_idle("basic", 400);
      end_checks("basic", 16, 1, 144);
      check("basic_latency_le_177", 32'((valid_cyc - t_start) <= 177), 32'd1);

      // signed compare
      clr_counts();
      sgn_w0 = '{16'hFFFB, 16'hFFFF, 16'h8000, 16'hFFF9, 16'hFFFE,
                 16'hFFF7, 16'hFFFD, 16'hFFFC, 16'hFFFA};
      for (int t = 0; t < 9; t++) push_word(sgn_w0[t]);
      exp_q.push_back(16'hFFFF);
      for (int t = 0; t < 9; t++) push_word(16'h8000);
      exp_q.push_back(16'h8000);
      for (int t = 0; t < 9; t++) push_word((t == 5) ? 16'h0001 : 16'hFFFF);
      exp_q.push_back(16'h0001);
      for (int k = 3; k < 16; k++) begin
         v = (k % 2 == 1) ? k * 100 : k * 100 - 3000;
         for (int t = 0; t < 9; t++) push_word((t == k % 9) ? 16'(v) : 16'(-20000 + t));
         exp_q.push_back(16'(v));
      end
      start_group(1'b0);
      wait_idle("signed", 400);
      end_checks("signed", 16, 1, 144);

      // empty stall: one word every 3 cycles
      clr_counts();
      for (int k = 0; k < 16; k++) exp_q.push_back(16'(500 + k));
      start_group(1'b0);
      for (int k = 0; k < 16; k++) begin
         for (int t = 0; t < 9; t++) begin
            push_word((t == 4) ? 16'(500 + k) : 16'(k * 3 + t));
            repeat (3) tick();
         end
      end
      wait_idle("trickle", 60);
      end_checks("trickle", 16, 1, 144);

      // output backpressure at the first write
      clr_counts();
      out_fifo_full = 1'b1;
      first_exp = 16'(-7000 + 8);
      for (int k = 0; k < 16; k++) begin
         for (int t = 0; t < 9; t++) push_word(16'(k * 1000 - 7000 + t));
         exp_q.push_back(16'(k * 1000 - 7000 + 8));
      end
      start_group(1'b0);
      for (int i = 0; i < 30 && pop_cnt < 9; i++) tick();
      repeat (3) tick();
      for (int i = 0; i < 17; i++) begin
         check("bp_din_stable", 32'(out_fifo_din), 32'(first_exp));
         check("bp_no_pops", 32'(pop_cnt), 32'd9);
         tick();
      end
      out_fifo_full = 1'b0;
      wait_idle("bp", 400);
      end_checks("bp", 16, 1, 144);

      // multi-group, ready dropped 50 cycles into the third group
      clr_counts();
      for (int g = 0; g < 48; g++) begin
         for (int t = 0; t < 9; t++) push_word(16'(g * 5 + ((t == g % 9) ? 200 : t)));
         exp_q.push_back(16'(g * 5 + 200));
      end
      start_group(1'b1);
      for (int i = 0; i < 600 && valid_cnt < 2; i++) tick();
      repeat (50) tick();
      maxpool_ready = 1'b0;
      wait_idle("multi", 300);
      end_checks("multi", 48, 3, 432);

      // reset in the middle of a window
      clr_counts();
      for (int t = 0; t < 9; t++) push_word(16'h7000);
      start_group(1'b0);
      for (int i = 0; i < 20 && pop_cnt < 4; i++) tick();
      check("mid_pops", 32'(pop_cnt), 32'd4);
      rst_n = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      data_fifo_empty = 1'b1;
      @(negedge clk);
      check_outs_zero("mid_rst");
      tick();
      rst_n = 1'b1;
      tick();
      clr_counts();
      for (int k = 0; k < 16; k++) begin
         for (int t = 0; t < 9; t++) push_word(16'(t * 2 - 100 + k));
         exp_q.push_back(16'(k - 84));
      end
      start_group(1'b0);
      wait_idle("post_rst", 400);
      end_checks("post_rst", 16, 1, 144);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
